// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and state type for the instruction-memory responder.
package imem_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: word storage with synchronous write and combinational read.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Combinational read sees the pre-write contents in a same-cycle write.
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding fetch responder with fixed latency,
// held responses, flush cancellation and a preload write port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_instr_q, rsp_addr_q, rdata;
    logic             rsp_err_q, accept, err, unused_load_bits;

    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr[AW+1:2]),
        .wdata_i (load_data),
        .raddr_i (req_addr[AW+1:2]),
        .rdata_o (rdata)
    );

    assign unused_load_bits = ^{load_addr[31:AW+2], load_addr[1:0]};
    assign accept = req_valid & req_ready & ~flush;
    assign err = (req_addr[1:0] != 2'b00) | ((req_addr >> (AW + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds remaining BUSY cycles; RESP is entered as it steps 1 -> 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = (LATENCY == 1) ? RESP : BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
        end else if (state_q == BUSY) begin
            state_d = (cnt_q == CNT_W'(1)) ? RESP : BUSY;
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        req_ready = ~flush & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
        rsp_valid = (state_q == RESP);
    end

    // Response is captured at accept so later preloads cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_instr_q <= NOP_INSTR;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_instr_q <= err ? NOP_INSTR : rdata;
            rsp_addr_q  <= req_addr;
            rsp_err_q   <= err;
        end
    end

    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder (LATENCY=2, 1024 words).
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst, req_valid, req_ready, flush, rsp_valid, rsp_ready;
    logic        rsp_err, load_en;
    logic [31:0] req_addr, rsp_instr, rsp_addr, load_addr, load_data;
    int          checks = 0, failures = 0;

    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] instr,
                              input logic [31:0] addr, input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_instr"}, rsp_instr, instr);
        chk({tag, "_addr"}, rsp_addr, addr);
        chk({tag, "_err"}, 32'(rsp_err), 32'(err));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00A0_0113);
        load(32'h8, 32'h0020_81B3);
        load(32'hFFC, 32'hCAFE_F00D);
        rst = 1'b0; #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_instr", rsp_instr, NOP);
        chk("rst_addr", rsp_addr, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        flush = 1'b1; #1;
        chk("idle_flush_ready", 32'(req_ready), 32'd0);
        flush = 1'b0;
        // Single request, then consumer stalls for 5 cycles.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("lat_busy_valid", 32'(rsp_valid), 32'd0);
        tick();
        expect_rsp("first", 32'h0050_0093, 32'h0, 1'b0);
        chk("first_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) load(32'h0, 32'h1111_1111);
            else if (i == 1) load(32'h0, 32'h0050_0093);
            else tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_instr", rsp_instr, 32'h0050_0093);
            chk("hold_addr", rsp_addr, 32'h0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        // Back-to-back stream with the consumer always ready.
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0; #1;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_addr = 32'h4;
        chk("s0_busy", 32'(rsp_valid), 32'd0);
        tick();
        expect_rsp("s0", 32'h0050_0093, 32'h0, 1'b0);
        tick();
        req_addr = 32'h8;
        chk("s1_busy", 32'(rsp_valid), 32'd0);
        tick();
        expect_rsp("s1", 32'h00A0_0113, 32'h4, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("s2_busy", 32'(rsp_valid), 32'd0);
        tick();
        expect_rsp("s2", 32'h0020_81B3, 32'h8, 1'b0);
        tick();
        chk("s_idle", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        // Flush while BUSY cancels the request.
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0; flush = 1'b1; #1;
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0; #1;
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("post_flush_ready", 32'(req_ready), 32'd1);
        tick();
        chk("flush_no_late", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        expect_rsp("after_flush", 32'h0020_81B3, 32'h8, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_resp_valid", 32'(rsp_valid), 32'd0);
        // Misaligned and out-of-range requests.
        req_valid = 1'b1; req_addr = 32'h2;
        tick();
        req_valid = 1'b0;
        tick();
        expect_rsp("misalign", NOP, 32'h2, 1'b1);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h1000;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        expect_rsp("oor", NOP, 32'h1000, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // Last valid word is in range.
        req_valid = 1'b1; req_addr = 32'hFFC;
        tick();
        req_valid = 1'b0;
        tick();
        expect_rsp("top_word", 32'hCAFE_F00D, 32'hFFC, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // Same-cycle load and accept to one word returns the old data.
        req_valid = 1'b1; req_addr = 32'h8;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'h1234_5678;
        tick();
        req_valid = 1'b0; load_en = 1'b0;
        tick();
        expect_rsp("rbw_old", 32'h0020_81B3, 32'h8, 1'b0);
        rsp_ready = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        expect_rsp("rbw_new", 32'h1234_5678, 32'h8, 1'b0);
        // Reset during RESP drops the response but keeps memory.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_instr", rsp_instr, NOP);
        chk("rst_resp_addr", rsp_addr, 32'h0);
        chk("rst_resp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        expect_rsp("mem_kept", 32'h00A0_0113, 32'h4, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
